pe_msg_port: RTL and testbench

//  Processing-element side endpoint of the mesh message network. It sits between one PE
//  and its router's self ports.
//  - TX path: builds full messages from PE send requests and injects them into the router

---
 rtl/pe_msg_port_pkg.sv | 50 +++++
 rtl/pe_msg_port_fifo2.sv | 54 +++++
 rtl/pe_msg_port.sv | 164 ++++++++++++++++
 tb/tb_pe_msg_port.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_msg_port_pkg.sv
// Shared message-network definitions: field widths, field offsets and
// pack/unpack helpers for the default 44-bit message layout.
package pe_msg_port_pkg;

    localparam int CW     = 4;
    localparam int COST_W = 2;
    localparam int HOP_W  = 4;
    localparam int TS_W   = 8;
    localparam int TYPE_W = 2;
    localparam int MSG_W  = 7*CW + COST_W + HOP_W + TS_W + TYPE_W;

    // Field offsets, LSB position of each field (message is MSB-first dest..type)
    localparam int TYPE_LSB = 0;
    localparam int TS_LSB   = TYPE_LSB + TYPE_W;
    localparam int HOP_LSB  = TS_LSB + TS_W;
    localparam int COST_LSB = HOP_LSB + HOP_W;
    localparam int ROOT_LSB = COST_LSB + COST_W;
    localparam int SRC_LSB  = ROOT_LSB + 3*CW;
    localparam int DEST_LSB = SRC_LSB + 2*CW;

    // Multicast marker and direction bit positions inside dest_col
    localparam logic [CW-1:0] BCAST_ROW = '1;
    localparam int DIR_N = 3;
    localparam int DIR_E = 2;
    localparam int DIR_W = 1;
    localparam int DIR_S = 0;

    typedef struct packed {
        logic [CW-1:0]     dest_row;
        logic [CW-1:0]     dest_col;
        logic [CW-1:0]     src_row;
        logic [CW-1:0]     src_col;
        logic [CW-1:0]     root_row;
        logic [CW-1:0]     root_col;
        logic [CW-1:0]     root_layer;
        logic [COST_W-1:0] cost;
        logic [HOP_W-1:0]  hop;
        logic [TS_W-1:0]   ts;
        logic [TYPE_W-1:0] typ;
    } msg_t;

    function automatic logic [MSG_W-1:0] msg_pack(input msg_t m);
        return m;
    endfunction

    function automatic msg_t msg_unpack(input logic [MSG_W-1:0] v);
        return v;
    endfunction

endpackage

// File: rtl/pe_msg_port_fifo2.sv
// Two-entry register FIFO with full/empty flags. A push into a full FIFO
// is ignored, even when a pop in the same cycle frees a slot.
module pe_msg_port_fifo2
    import pe_msg_port_pkg::*;
#(
    parameter int WIDTH = MSG_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // storage, pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop)
                rd_ptr <= ~rd_ptr;
            if (do_push && !do_pop)
                count <= count + 2'd1;
            else if (!do_push && do_pop)
                count <= count - 2'd1;
        end
    end

    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);
    assign dout  = mem[rd_ptr];

endmodule

// File: rtl/pe_msg_port.sv
// PE-side endpoint of the mesh message network: builds and injects
// messages into the router self mailbox, decodes deliveries for the PE,
// and keeps traffic counters plus an idle flag for convergence detection.
module pe_msg_port
    import pe_msg_port_pkg::*;
#(
    parameter int CORDINATE_WIDTH = CW,
    parameter int COST_WIDTH      = COST_W,
    parameter int MAX_HOP_WIDTH   = HOP_W,
    parameter int TIMESTAMP_WIDTH = TS_W,
    parameter int MSG_TYPE_WIDTH  = TYPE_W,
    parameter int MSG_WIDTH       = 7*CORDINATE_WIDTH + COST_WIDTH + MAX_HOP_WIDTH
                                    + TIMESTAMP_WIDTH + MSG_TYPE_WIDTH,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [CORDINATE_WIDTH-1:0]   ROW_ID,
    input  logic [CORDINATE_WIDTH-1:0]   COL_ID,
    input  logic                         tx_valid,
    output logic                         tx_ready,
    input  logic                         tx_bcast,
    input  logic [3:0]                   tx_dir_mask,
    input  logic [CORDINATE_WIDTH-1:0]   tx_dest_row,
    input  logic [CORDINATE_WIDTH-1:0]   tx_dest_col,
    input  logic [3*CORDINATE_WIDTH-1:0] tx_root,
    input  logic [COST_WIDTH-1:0]        tx_cost,
    input  logic [MAX_HOP_WIDTH-1:0]     tx_hop,
    input  logic [MSG_TYPE_WIDTH-1:0]    tx_type,
    output logic [MSG_WIDTH-1:0]         self_value_out,
    output logic                         self_valid_out,
    input  logic                         self_ready_in,
    input  logic [MSG_WIDTH-1:0]         self_value_in,
    input  logic                         self_valid_in,
    output logic                         self_ready_out,
    output logic                         rx_valid,
    input  logic                         rx_ready,
    output logic [2*CORDINATE_WIDTH-1:0] rx_src,
    output logic [3*CORDINATE_WIDTH-1:0] rx_root,
    output logic [COST_WIDTH-1:0]        rx_cost,
    output logic [MAX_HOP_WIDTH-1:0]     rx_hop,
    output logic [TIMESTAMP_WIDTH-1:0]   rx_ts,
    output logic [MSG_TYPE_WIDTH-1:0]    rx_type,
    output logic [CNT_WIDTH-1:0]         tx_count,
    output logic [CNT_WIDTH-1:0]         rx_count,
    output logic [CNT_WIDTH-1:0]         drop_count,
    output logic                         idle
);

    localparam int HLSB = MSG_TYPE_WIDTH + TIMESTAMP_WIDTH;
    localparam int CLSB = HLSB + MAX_HOP_WIDTH;
    localparam int RLSB = CLSB + COST_WIDTH;
    localparam int SLSB = RLSB + 3*CORDINATE_WIDTH;

    logic [TIMESTAMP_WIDTH-1:0] ts;
    logic                       port_en;
    logic [CORDINATE_WIDTH-1:0] dest_row;
    logic [CORDINATE_WIDTH-1:0] dest_col;
    logic [MSG_WIDTH-1:0]       tx_msg;
    logic                       tx_push;
    logic                       tx_full;
    logic                       tx_empty;
    logic [MAX_HOP_WIDTH-1:0]   hop_in;
    logic                       rx_expired;
    logic                       rx_push;
    logic                       rx_pop;
    logic [MSG_WIDTH-1:0]       rx_msg;
    logic [MSG_WIDTH-1:0]       rx_head;
    logic                       rx_full;
    logic                       rx_empty;
    logic                       unused_rx_dest;

    // free-running timestamp; port_en holds both readies low until the cycle after reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts      <= '0;
            port_en <= 1'b0;
        end else begin
            ts      <= ts + TIMESTAMP_WIDTH'(1);
            port_en <= 1'b1;
        end
    end

    // multicast replaces the destination with the all-ones row and the direction mask
    always_comb begin
        dest_row = tx_dest_row;
        dest_col = tx_dest_col;
        if (tx_bcast) begin
            dest_row      = '1;
            dest_col      = '0;
            dest_col[3:0] = tx_dir_mask;
        end
    end

    assign tx_msg   = {dest_row, dest_col, ROW_ID, COL_ID, tx_root,
                       tx_cost, tx_hop, ts, tx_type};
    assign tx_ready = port_en && !tx_full;
    // an empty multicast mask is accepted but goes nowhere
    assign tx_push  = tx_valid && tx_ready && !(tx_bcast && (tx_dir_mask == 4'b0000));
    // the mailbox writes on valid alone, so valid must never rise without ready
    assign self_valid_out = !tx_empty && self_ready_in;

    pe_msg_port_fifo2 #(.WIDTH(MSG_WIDTH)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_push),
        .pop   (self_valid_out),
        .din   (tx_msg),
        .dout  (self_value_out),
        .full  (tx_full),
        .empty (tx_empty)
    );

    assign hop_in     = self_value_in[HLSB +: MAX_HOP_WIDTH];
    assign rx_expired = self_valid_in && (hop_in == '0);
    assign rx_push    = self_valid_in && !rx_expired;
    assign rx_msg     = {self_value_in[MSG_WIDTH-1:CLSB], hop_in - MAX_HOP_WIDTH'(1),
                         self_value_in[HLSB-1:0]};
    assign self_ready_out = port_en && !rx_full;
    assign rx_valid       = !rx_empty;
    assign rx_pop         = rx_valid && rx_ready;

    pe_msg_port_fifo2 #(.WIDTH(MSG_WIDTH)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_push),
        .pop   (rx_pop),
        .din   (rx_msg),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );

    assign rx_src  = rx_head[SLSB +: 2*CORDINATE_WIDTH];
    assign rx_root = rx_head[RLSB +: 3*CORDINATE_WIDTH];
    assign rx_cost = rx_head[CLSB +: COST_WIDTH];
    assign rx_hop  = rx_head[HLSB +: MAX_HOP_WIDTH];
    assign rx_ts   = rx_head[MSG_TYPE_WIDTH +: TIMESTAMP_WIDTH];
    assign rx_type = rx_head[0 +: MSG_TYPE_WIDTH];
    // destination is meaningless once the message has reached this PE
    assign unused_rx_dest = ^rx_head[MSG_WIDTH-1 -: 2*CORDINATE_WIDTH];

    // saturating traffic counters and the registered idle flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_count   <= '0;
            rx_count   <= '0;
            drop_count <= '0;
            idle       <= 1'b0;
        end else begin
            if (self_valid_out && (tx_count != '1))
                tx_count <= tx_count + CNT_WIDTH'(1);
            if (rx_pop && (rx_count != '1))
                rx_count <= rx_count + CNT_WIDTH'(1);
            if (rx_expired && (drop_count != '1))
                drop_count <= drop_count + CNT_WIDTH'(1);
            idle <= tx_empty && rx_empty && !tx_valid && !self_valid_in;
        end
    end

    // a delivery into a full RX buffer is lost; the router must honour self_ready_out
    assert property (@(posedge clk) disable iff (reset) !(self_valid_in && rx_full));

endmodule

// File: tb/tb_pe_msg_port.sv
// Scoreboard bench for pe_msg_port: directed scenarios plus random traffic,
// checked against a queue-based model of the two buffers.
module tb_pe_msg_port;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  ROW_ID = 4'd2;
    logic [3:0]  COL_ID = 4'd3;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic        tx_bcast = 1'b0;
    logic [3:0]  tx_dir_mask = 4'd0;
    logic [3:0]  tx_dest_row = 4'd0;
    logic [3:0]  tx_dest_col = 4'd0;
    logic [11:0] tx_root = 12'd0;
    logic [1:0]  tx_cost = 2'd0;
    logic [3:0]  tx_hop = 4'd0;
    logic [1:0]  tx_type = 2'd0;
    logic [43:0] self_value_out;
    logic        self_valid_out;
    logic        self_ready_in = 1'b0;
    logic [43:0] self_value_in = 44'd0;
    logic        self_valid_in = 1'b0;
    logic        self_ready_out;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic [7:0]  rx_src;
    logic [11:0] rx_root;
    logic [1:0]  rx_cost;
    logic [3:0]  rx_hop;
    logic [7:0]  rx_ts;
    logic [1:0]  rx_type;
    logic [15:0] tx_count;
    logic [15:0] rx_count;
    logic [15:0] drop_count;
    logic        idle;

    pe_msg_port dut (
        .clk(clk), .reset(reset), .ROW_ID(ROW_ID), .COL_ID(COL_ID),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_bcast(tx_bcast),
        .tx_dir_mask(tx_dir_mask), .tx_dest_row(tx_dest_row), .tx_dest_col(tx_dest_col),
        .tx_root(tx_root), .tx_cost(tx_cost), .tx_hop(tx_hop), .tx_type(tx_type),
        .self_value_out(self_value_out), .self_valid_out(self_valid_out),
        .self_ready_in(self_ready_in), .self_value_in(self_value_in),
        .self_valid_in(self_valid_in), .self_ready_out(self_ready_out),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_src(rx_src), .rx_root(rx_root),
        .rx_cost(rx_cost), .rx_hop(rx_hop), .rx_ts(rx_ts), .rx_type(rx_type),
        .tx_count(tx_count), .rx_count(rx_count), .drop_count(drop_count), .idle(idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  src;
        logic [11:0] root;
        logic [1:0]  cost;
        logic [3:0]  hop;
        logic [7:0]  ts;
        logic [1:0]  ty;
    } rx_t;

    logic [43:0] txq[$];
    rx_t         rxq[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          tx_cnt_m = 0;
    int          rx_cnt_m = 0;
    int          drop_m = 0;
    logic        exp_idle = 1'b0;
    logic        exp_tx_ready = 1'b0;
    logic        pre_tx_empty = 1'b1;
    logic        pre_rx_empty = 1'b1;
    int unsigned cyc;

    // cycles since reset release; the timestamp is this count modulo 256
    always @(posedge clk or posedge reset)
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [43:0] mk_tx(input logic b, input logic [3:0] m,
                                          input logic [3:0] dr, input logic [3:0] dc,
                                          input logic [11:0] root, input logic [1:0] cost,
                                          input logic [3:0] hop, input logic [7:0] ts,
                                          input logic [1:0] ty);
        logic [3:0] r;
        logic [3:0] c;
        r = b ? 4'hF : dr;
        c = b ? m : dc;
        return {r, c, ROW_ID, COL_ID, root, cost, hop, ts, ty};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_tx_fields();
        tx_dest_row = 4'($urandom);
        tx_dest_col = 4'($urandom);
        tx_root     = 12'($urandom);
        tx_cost     = 2'($urandom);
        tx_hop      = 4'($urandom);
        tx_type     = 2'($urandom);
        tx_dir_mask = 4'($urandom);
    endtask

    task automatic set_rx(input logic [3:0] hop);
        self_value_in = {8'($urandom), 8'($urandom), 12'($urandom), 2'($urandom),
                         hop, 8'($urandom), 2'($urandom)};
        self_valid_in = 1'b1;
    endtask

    // monitor: compare outputs with the model, then retire this cycle's transfers
    initial forever begin
        @(negedge clk);
        if (reset) begin
            chk("rst_self_valid_out", self_valid_out, 0);
            chk("rst_rx_valid", rx_valid, 0);
            chk("rst_tx_ready", tx_ready, 0);
            chk("rst_self_ready_out", self_ready_out, 0);
            chk("rst_counts", {tx_count, rx_count, drop_count}, 0);
            chk("rst_idle", idle, 0);
            txq.delete();
            rxq.delete();
            tx_cnt_m = 0;
            rx_cnt_m = 0;
            drop_m = 0;
            exp_tx_ready = 1'b0;
            pre_tx_empty = 1'b1;
            pre_rx_empty = 1'b1;
        end else begin
            exp_tx_ready = (cyc != 0) && (txq.size() < 2);
            pre_tx_empty = (txq.size() == 0);
            pre_rx_empty = (rxq.size() == 0);
            chk("tx_ready", tx_ready, exp_tx_ready);
            chk("self_ready_out", self_ready_out, (cyc != 0) && (rxq.size() < 2));
            chk("tx_count", tx_count, tx_cnt_m);
            chk("rx_count", rx_count, rx_cnt_m);
            chk("drop_count", drop_count, drop_m);
            chk("idle", idle, exp_idle);
            chk("self_valid_out", self_valid_out, (txq.size() != 0) && self_ready_in);
            if (txq.size() != 0 && self_ready_in) begin
                chk("self_value_out", self_value_out, txq.pop_front());
                tx_cnt_m++;
            end
            chk("rx_valid", rx_valid, rxq.size() != 0);
            if (rxq.size() != 0) begin
                chk("rx_src", rx_src, rxq[0].src);
                chk("rx_root", rx_root, rxq[0].root);
                chk("rx_cost", rx_cost, rxq[0].cost);
                chk("rx_hop", rx_hop, rxq[0].hop);
                chk("rx_ts", rx_ts, rxq[0].ts);
                chk("rx_type", rx_type, rxq[0].ty);
                if (rx_ready) begin
                    void'(rxq.pop_front());
                    rx_cnt_m++;
                end
            end
        end
    end

    // expectation side: late in the cycle, record what this cycle's requests should produce
    initial forever begin
        rx_t        r;
        logic [3:0] h;
        @(negedge clk);
        #4;
        if (reset) begin
            exp_idle = 1'b0;
        end else begin
            exp_idle = pre_tx_empty && pre_rx_empty && !tx_valid && !self_valid_in;
            if (tx_valid && exp_tx_ready && !(tx_bcast && tx_dir_mask == 4'd0))
                txq.push_back(mk_tx(tx_bcast, tx_dir_mask, tx_dest_row, tx_dest_col, tx_root,
                                    tx_cost, tx_hop, 8'(cyc), tx_type));
            if (self_valid_in) begin
                h = self_value_in[13:10];
                if (h == 4'd0) begin
                    drop_m++;
                end else begin
                    r.src  = self_value_in[35:28];
                    r.root = self_value_in[27:16];
                    r.cost = self_value_in[15:14];
                    r.hop  = h - 4'd1;
                    r.ts   = self_value_in[9:2];
                    r.ty   = self_value_in[1:0];
                    rxq.push_back(r);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        step();
        step();
        @(posedge clk);
        #7 reset = 1'b0;

        // unicast stamped with timestamp 0x10
        self_ready_in = 1'b1;
        rx_ready = 1'b1;
        while (cyc != 16) step();
        rand_tx_fields();
        tx_valid = 1'b1; tx_bcast = 1'b0;
        tx_dest_row = 4'd5; tx_dest_col = 4'd1; tx_hop = 4'd3;
        step();
        tx_valid = 1'b0;
        #3;
        chk("t1_valid", self_valid_out, 1);
        chk("t1_dest_src", self_value_out[43:28], 16'h5123);
        chk("t1_hop_ts", {self_value_out[13:10], self_value_out[9:2]}, 12'h310);
        step();
        #3 chk("t1_tx_count", tx_count, 1);

        // multicast mask 1010, then an empty mask
        rand_tx_fields();
        tx_valid = 1'b1; tx_bcast = 1'b1; tx_dir_mask = 4'b1010;
        step();
        tx_dir_mask = 4'b0000;
        #3;
        chk("t2_valid", self_valid_out, 1);
        chk("t2_dest", self_value_out[43:36], 8'hFA);
        step();
        tx_valid = 1'b0; tx_bcast = 1'b0;
        #3;
        chk("t2_mask0_valid", self_valid_out, 0);
        chk("t2_tx_count", tx_count, 2);

        // backpressure: three requests, two accepted, drained in order later
        self_ready_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            rand_tx_fields();
            tx_valid = 1'b1;
        end
        step();
        tx_valid = 1'b0;
        #3;
        chk("t3_tx_ready", tx_ready, 0);
        chk("t3_no_valid", self_valid_out, 0);
        step();
        self_ready_in = 1'b1;
        #3 chk("t3_drain0", self_valid_out, 1);
        step();
        #3 chk("t3_drain1", self_valid_out, 1);
        step();
        #3 chk("t3_drained", self_valid_out, 0);

        // RX: expired drop, hop decrement, full buffer
        rx_ready = 1'b0;
        set_rx(4'd0);
        step();
        self_valid_in = 1'b0;
        step();
        #3;
        chk("t4_drop", drop_count, 1);
        chk("t4_rx_empty", rx_valid, 0);
        set_rx(4'd2);
        step();
        set_rx(4'd3);
        step();
        self_valid_in = 1'b0;
        #3;
        chk("t4_rx_hop", rx_hop, 1);
        chk("t4_full_ready", self_ready_out, 0);
        rx_ready = 1'b1;
        step();
        step();
        step();

        // send in the cycle the timestamp reads 0xFF
        while ((cyc % 256) != 255) step();
        rand_tx_fields();
        tx_valid = 1'b1; tx_bcast = 1'b0;
        step();
        tx_valid = 1'b0;
        #3 chk("t5_ts_wrap", self_value_out[9:2], 8'hFF);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step();
            rand_tx_fields();
            tx_valid      = 1'($urandom_range(0, 1));
            tx_bcast      = ($urandom_range(0, 3) == 0);
            self_ready_in = ($urandom_range(0, 3) != 0);
            rx_ready      = ($urandom_range(0, 2) != 0);
            if (rxq.size() < 2 && cyc != 0 && $urandom_range(0, 1) == 1)
                set_rx(4'($urandom_range(0, 3)));
            else
                self_valid_in = 1'b0;
        end
        step();
        tx_valid = 1'b0; self_valid_in = 1'b0; self_ready_in = 1'b1; rx_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();

        // fill both buffers, then reset mid-cycle
        self_ready_in = 1'b0;
        rx_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rand_tx_fields();
            tx_valid = 1'b1; tx_bcast = 1'b0;
            set_rx(4'd1 + 4'($urandom_range(0, 7)));
            step();
        end
        tx_valid = 1'b0;
        self_valid_in = 1'b0;
        step();
        #3 chk("t6_rx_full_valid", rx_valid, 1);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("t6_valids_low", {self_valid_out, rx_valid}, 0);
        chk("t6_counts_zero", {tx_count, rx_count, drop_count}, 0);
        @(posedge clk);
        #7 reset = 1'b0;
        @(posedge clk);
        #2 chk("t6_idle_after", idle, 1);
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
